// File: rtl/keypad_scan_4x4.sv
// ---------------------------------------------------------------------------
// keypad_scan_4x4
//   Scans a 4x4 matrix keypad and debounces both presses and releases. It
//   reports the accepted key as a hex code {row[1:0], col[1:0]} with a
//   one-cycle valid pulse. All FSM transitions happen only on scan ticks.
//
// Ports:
//   sys_clk    in   system clock (50 MHz nominal)
//   sys_rst_n  in   asynchronous active-low reset
//   key_col    in   [3:0] column lines, active-low, pulled up, asynchronous
//   key_row    out  [3:0] row drive, active-low (0 = row driven)
//   key_code   out  [3:0] last accepted key code, held until the next press
//   key_valid  out  one-cycle pulse when a new key_code is accepted
//   key_held   out  high while the accepted key remains pressed
//
// Optional feature:
//   KEY_REPEAT_EN  when defined, a held key re-pulses key_valid every
//                  REPEAT_TICKS scan ticks. The key_code is unchanged.
// ---------------------------------------------------------------------------
module keypad_scan_4x4 #(
    parameter logic [15:0] SCAN_CNT_MAX   = 16'd49_999,
    parameter logic [4:0]  DEBOUNCE_SCANS = 5'd20
`ifdef KEY_REPEAT_EN
    ,
    parameter logic [9:0]  REPEAT_TICKS   = 10'd500
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        SCAN,
        HOLD,
        DEB_REL
    } state_t;

    state_t      state, state_next;
    logic [3:0]  col_meta, col_sync;
    logic [15:0] tick_cnt;
    logic        tick;
    logic [1:0]  row_idx, row_idx_next;
    logic [4:0]  deb_cnt, deb_cnt_next, deb_cnt_inc;
    logic        deb_done;
    logic [3:0]  key_row_next, key_code_next;
    logic        key_valid_next, key_held_next;
    logic        col_any, col_one_hot;
    logic [1:0]  col_idx;
`ifdef KEY_REPEAT_EN
    logic [9:0]  rep_cnt, rep_cnt_next;
`endif

    // Two-flop synchroniser. It resets to "no key" so a reset never looks like a press.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= key_col;
            col_sync <= col_meta;
        end
    end

    // Scan tick divider: one tick every SCAN_CNT_MAX+1 clocks.
    assign tick = (tick_cnt == SCAN_CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tick_cnt <= '0;
        else            tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
    end

    // Column decode. Zero or several low columns is not a valid hit.
    // With several low columns, the reading is a possible ghost.
    assign col_any = (col_sync != 4'hF);

    always_comb begin
        col_one_hot = 1'b1;
        col_idx     = 2'd0;
        case (col_sync)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_one_hot = 1'b0;
        endcase
    end

    // Debounce count saturates at DEBOUNCE_SCANS.
    assign deb_cnt_inc = (deb_cnt < DEBOUNCE_SCANS) ? deb_cnt + 5'd1 : deb_cnt;
    assign deb_done    = (deb_cnt_inc >= DEBOUNCE_SCANS);

    // Next-state and registered-output logic.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next     = state;
        row_idx_next   = row_idx;
        deb_cnt_next   = deb_cnt;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
`ifdef KEY_REPEAT_EN
        rep_cnt_next   = rep_cnt;
`endif

        if (tick) begin
            case (state)
                IDLE: begin
                    if (col_any) begin
                        deb_cnt_next = 5'd1;
                        state_next   = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!col_any) begin
                        deb_cnt_next = '0;
                        state_next   = IDLE;
                    end else if (deb_done) begin
                        deb_cnt_next = '0;
                        row_idx_next = 2'd0;
                        state_next   = SCAN;
                    end else begin
                        deb_cnt_next = deb_cnt_inc;
                    end
                end
                SCAN: begin
                    if (col_one_hot) begin
                        key_code_next  = {row_idx, col_idx};
                        key_valid_next = 1'b1;
                        key_held_next  = 1'b1;
                        state_next     = HOLD;
`ifdef KEY_REPEAT_EN
                        rep_cnt_next   = '0;
`endif
                    end else if (row_idx == 2'd3) begin
                        row_idx_next = 2'd0;
                        state_next   = IDLE;
                    end else begin
                        row_idx_next = row_idx + 2'd1;
                    end
                end
                HOLD: begin
                    // Only the accepted row is driven, so keys in other rows are invisible here.
                    if (!col_any) begin
                        deb_cnt_next = 5'd1;
                        state_next   = DEB_REL;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rep_cnt + 10'd1 >= REPEAT_TICKS) begin
                        key_valid_next = 1'b1;
                        rep_cnt_next   = '0;
                    end else begin
                        rep_cnt_next = rep_cnt + 10'd1;
                    end
`else
                    // Without auto-repeat a held key stays silent until release.
`endif
                end
                DEB_REL: begin
                    if (col_any) begin
                        deb_cnt_next = '0;
                        state_next   = HOLD;
`ifdef KEY_REPEAT_EN
                        rep_cnt_next = '0;
`endif
                    end else if (deb_done) begin
                        deb_cnt_next  = '0;
                        key_held_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        deb_cnt_next = deb_cnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Row drive follows the state being entered, so it changes on the same edge.
        case (state_next)
            SCAN, HOLD, DEB_REL: key_row_next = ~(4'b0001 << row_idx_next);
            default:             key_row_next = 4'b0000;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            row_idx   <= '0;
            deb_cnt   <= '0;
            key_row   <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            row_idx   <= row_idx_next;
            deb_cnt   <= deb_cnt_next;
            key_row   <= key_row_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rep_cnt <= '0;
        else            rep_cnt <= rep_cnt_next;
    end
`endif

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_4x4
//   Directed bench for keypad_scan_4x4 with SCAN_CNT_MAX=9 (tick every 10
//   clocks) and DEBOUNCE_SCANS=3. A small keypad model pulls the pressed
//   key's columns low only while that key's row is driven. A force path
//   applies raw column patterns to model bounce.
// ---------------------------------------------------------------------------
module tb_keypad_scan_4x4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Keypad model state.
    logic       key_on    = 1'b0;
    logic [1:0] key_r     = 2'd0;
    logic [3:0] key_mask  = 4'b0000;
    logic       force_en  = 1'b0;
    logic [3:0] force_col = 4'hF;

    int errors      = 0;
    int checks      = 0;
    int valid_cnt   = 0;
    bit prev_valid  = 1'b0;
    bit consec_seen = 1'b0;

    keypad_scan_4x4 #(
        .SCAN_CNT_MAX  (16'd9),
        .DEBOUNCE_SCANS(5'd3)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_TICKS  (10'd4)
`endif
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_col  (key_col),
        .key_row  (key_row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        key_col = 4'hF;
        if (force_en)                     key_col = force_col;
        else if (key_on && !key_row[key_r]) key_col = ~key_mask;
    end

    // Pulse monitor, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (key_valid) valid_cnt++;
        if (key_valid && prev_valid) consec_seen = 1'b1;
        prev_valid = key_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    // Waits for a key_valid pulse within a cycle budget. A timeout counts as a failure.
    task automatic wait_valid(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge sys_clk);
            #1;
            if (key_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: key_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [3:0] mask);
        key_r    = r;
        key_mask = mask;
        key_on   = 1'b1;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        wait_cycles(3);
        chk4("reset_row", key_row, 4'b1111);
        chk4("reset_code", key_code, 4'h0);
        chk4("reset_valid_held", {2'b00, key_valid, key_held}, 4'b0000);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        chk4("row_before_first_edge", key_row, 4'b1111);
        @(posedge sys_clk);
        #1;
        chk4("row_after_first_edge", key_row, 4'b0000);
        wait_cycles(200);
        chk_int("no_valid_idle", valid_cnt, 0);
    endtask

    task automatic test_clean_press;
        int base;
        int exp_pulses;
        base = valid_cnt;
        press(2'd2, 4'b0010);
        wait_valid("press_r2c1", 300);
        chk4("code_r2c1", key_code, 4'h9);
        chk4("held_r2c1", {3'b000, key_held}, 4'b0001);
        wait_cycles(100);
`ifdef KEY_REPEAT_EN
        exp_pulses = 3;
`else
        exp_pulses = 1;
`endif
        chk_int("pulses_r2c1", valid_cnt - base, exp_pulses);
        chk4("row_hold_r2", key_row, 4'b1011);
        key_on = 1'b0;
        wait_cycles(20);
        chk4("held_during_rel_deb", {3'b000, key_held}, 4'b0001);
        wait_cycles(15);
        chk4("held_cleared", {3'b000, key_held}, 4'b0000);
        chk4("row_idle_after_rel", key_row, 4'b0000);
        chk4("code_kept_after_rel", key_code, 4'h9);
        chk_int("no_pulse_on_release", valid_cnt - base, exp_pulses);
    endtask

    task automatic test_bounce;
        int base;
        base = valid_cnt;
        force_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            force_col = (((i / 7) % 2) == 0) ? 4'hD : 4'hF;
            @(negedge sys_clk);
        end
        force_col = 4'hF;
        wait_cycles(60);
        force_en = 1'b0;
        chk_int("bounce_no_valid", valid_cnt - base, 0);
        chk4("bounce_row_idle", key_row, 4'b0000);
        chk4("bounce_held", {3'b000, key_held}, 4'b0000);
    endtask

    task automatic test_corner_keys;
        int base;
        base = valid_cnt;
        press(2'd0, 4'b0001);
        wait_valid("press_r0c0", 300);
        chk4("code_r0c0", key_code, 4'h0);
        chk_int("pulses_r0c0", valid_cnt - base, 1);
        key_on = 1'b0;
        wait_cycles(40);
        chk4("held_clear_r0c0", {3'b000, key_held}, 4'b0000);
        base = valid_cnt;
        press(2'd3, 4'b1000);
        wait_valid("press_r3c3", 300);
        chk4("code_r3c3", key_code, 4'hF);
        chk4("row_hold_r3", key_row, 4'b0111);
        chk_int("pulses_r3c3", valid_cnt - base, 1);
        key_on = 1'b0;
        wait_cycles(40);
    endtask

    task automatic test_ghosting;
        int base;
        base = valid_cnt;
        press(2'd1, 4'b0101);
        wait_cycles(200);
        chk_int("ghost_no_valid", valid_cnt - base, 0);
        chk4("ghost_code_kept", key_code, 4'hF);
        chk4("ghost_held", {3'b000, key_held}, 4'b0000);
        key_on = 1'b0;
        wait_cycles(60);
        chk4("ghost_row_idle", key_row, 4'b0000);
    endtask

    task automatic test_reset_mid_hold;
        press(2'd2, 4'b1000);
        wait_valid("press_r2c3", 300);
        chk4("code_r2c3", key_code, 4'hB);
        wait_cycles(5);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk4("async_rst_row", key_row, 4'b1111);
        chk4("async_rst_code", key_code, 4'h0);
        chk4("async_rst_valid_held", {2'b00, key_valid, key_held}, 4'b0000);
        key_on = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk4("row_after_rst_release", key_row, 4'b0000);
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat;
        int base;
        press(2'd1, 4'b0100);
        wait_valid("press_r1c2", 300);
        chk4("code_r1c2", key_code, 4'h6);
        base = valid_cnt;
        wait_cycles(125);
        chk_int("repeat_pulses", valid_cnt - base, 3);
        chk4("repeat_code", key_code, 4'h6);
        key_on = 1'b0;
        wait_cycles(40);
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_corner_keys();
        test_ghosting();
        test_reset_mid_hold();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        chk_int("no_back_to_back_valid", int'(consec_seen), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
